sreg_deser: RTL and testbench
=============================

SREG_DESER -- requirements
Module: sreg_deser

Interface
REQ-001: sclk  input  1  sole clock; all state updates on rising edge.
REQ-002: rst_n  input  1  reset; synchronous and active-low.
REQ-003: load  input  1  frame-start strobe from the sending end; marks start of a new 42-bit word.
REQ-004: shift  input  1  pair-valid strobe; sreg_in is sampled on every cycle this is high while receiving.
REQ-005: sreg_in  input  2  serial data pair, MSB pair first (first pair = word[41:40], last pair = word[1:0]).
REQ-006: data_out  output  42  reassembled word; stable while data_valid=1.
REQ-007: data_valid  output  1  data_out holds an unconsumed word.
REQ-008: data_ready  input  1  consumer accept; a transfer occurs on any cycle with data_valid=1 and data_ready=1.
REQ-009: busy  output  1  high in RECV state.
REQ-010: ovf  output  1  one-cycle pulse; a completed word was dropped.
REQ-011: frm_err  output  1  one-cycle pulse; a partial frame was aborted by load.
REQ-012: err_cnt  output  8  error count; present only when SREG_DESER_ERR_CNT_EN is defined.

Function
REQ-013: FSM states: IDLE and RECV; the pair counter cnt is 5 bits, range 0..20.
REQ-014: IDLE + load=1 -> RECV with cnt=0 and accumulator cleared; shift is ignored in IDLE, including on the load cycle.
REQ-015: RECV + shift=1 + load=0: acc <= {acc[39:0], sreg_in}; cnt <= cnt+1.
REQ-016: RECV + shift=0 + load=0: hold acc and cnt; stalls of any length are legal.
REQ-017: RECV + shift=1 + load=0 + cnt=20 (21st pair) -> word complete: candidate word = {acc[39:0], sreg_in}; next state IDLE.
REQ-018: Word completion while the output register is free, or freed the same cycle by data_ready: data_out <= word and data_valid=1 on the next cycle; latency is one cycle after the 21st pair.
REQ-019: Word completion while data_valid=1 and data_ready=0: word dropped, data_out unchanged, ovf=1 for one cycle.
REQ-020: RECV + load=1 (regardless of shift): restart frame with cnt=0 and acc cleared; stay in RECV; frm_err=1 for one cycle if cnt>0; no word is emitted.
REQ-021: data_valid clears on the cycle after a transfer unless a new word loads that same cycle.
REQ-022: ovf and frm_err are mutually exclusive by construction.
REQ-023: busy=1 exactly when state is RECV.

Reset
REQ-024: rst_n=0 at a rising edge: state IDLE, cnt=0, acc=0, data_out=0, data_valid=0, busy=0, ovf=0, frm_err=0, err_cnt=0.
REQ-025: Reset mid-frame discards the partial word; reset with data_valid=1 discards the pending word; no error pulses are generated.
REQ-026: While rst_n=0, inputs are ignored; the first frame may start on the first cycle with rst_n=1.

Configuration
REQ-027: Macro SREG_DESER_ERR_CNT_EN defined: the err_cnt port exists; it increments by 1 on each ovf or frm_err pulse and saturates at 8'hFF.
REQ-028: Macro SREG_DESER_ERR_CNT_EN undefined: the err_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-029: Basic: load, then 21 shifts carrying 42'h2AB_CDEF_0123 MSB pair first, data_ready=1 -> data_valid=1 one cycle after the last pair, data_out=42'h2AB_CDEF_0123, busy falls with the last pair.
REQ-030: Stalls: same word with shift deasserted for 3 cycles after pairs 5 and 14 -> identical data_out, no error pulses.
REQ-031: Overflow: data_ready=0, two frames 42'h3FF_FFFF_FFFF then 42'h0 -> data_out stays 42'h3FF_FFFF_FFFF, ovf pulses once, err_cnt=1 (macro on).
REQ-032: Abort: load, 7 pairs, load again, then 21 pairs of 42'h155_5555_5555 -> frm_err pulses once, data_out=42'h155_5555_5555.
REQ-033: Back-to-back accept: pending word accepted (data_ready=1) on the same cycle a new word completes -> no ovf, the new word appears next cycle with data_valid held at 1.
REQ-034: Reset: rst_n=0 after 10 pairs, then a full frame of 42'h0F0_F0F0_F0F0 -> no stale bits, correct data_out, err_cnt=0.

Source files
------------

// File: rtl/sreg_deser.sv
// ============================================================================
// Module   : sreg_deser
// Purpose  : Deserialises 21 two-bit pairs into a 42-bit word with a
//            valid/ready output register. Optional error counter is enabled
//            by defining SREG_DESER_ERR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sreg_deser (
    input  logic        sclk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        shift,
    input  logic [1:0]  sreg_in,
    output logic [41:0] data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        busy,
    output logic        ovf,
    output logic        frm_err
`ifdef SREG_DESER_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam logic [4:0] c_LAST_PAIR = 5'd20;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [39:0] acc_q, acc_d;
    logic [41:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        ovf_q, ovf_d;
    logic        frm_err_q, frm_err_d;

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 40'd0;
            data_q    <= 42'd0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            frm_err_q <= frm_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ovf_d     = 1'b0;
        frm_err_d = 1'b0;

        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = RECV;
                    cnt_d   = 5'd0;
                    acc_d   = 40'd0;
                end
            end
            RECV: begin
                if (load) begin
                    cnt_d     = 5'd0;
                    acc_d     = 40'd0;
                    frm_err_d = (cnt_q != 5'd0);
                end else if (shift) begin
                    acc_d = {acc_q[37:0], sreg_in};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == c_LAST_PAIR) begin
                        state_d = IDLE;
                        cnt_d   = 5'd0;
                        // A word is only kept if the output register is free or drains this cycle.
                        if (!valid_q || data_ready) begin
                            data_d  = {acc_q, sreg_in};
                            valid_d = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = (state_q == RECV);
    assign ovf        = ovf_q;
    assign frm_err    = frm_err_q;

`ifdef SREG_DESER_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if ((ovf_q || frm_err_q) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sreg_deser.sv
// ============================================================================
// Module   : tb_sreg_deser
// Purpose  : Self-checking bench for sreg_deser: directed scenarios followed
//            by randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sreg_deser;

    logic        sclk = 1'b0;
    logic        rst_n;
    logic        load;
    logic        shift;
    logic [1:0]  sreg_in;
    logic [41:0] data_out;
    logic        data_valid;
    logic        data_ready;
    logic        busy;
    logic        ovf;
    logic        frm_err;
`ifdef SREG_DESER_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    always #5 sclk = ~sclk;

    sreg_deser u_dut (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .load       (load),
        .shift      (shift),
        .sreg_in    (sreg_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .ovf        (ovf),
        .frm_err    (frm_err)
`ifdef SREG_DESER_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the frame is a queue of received pairs, folded into a word arithmetically.
    logic [1:0]  m_pairs[$];
    bit          m_rec;
    logic [41:0] m_data;
    bit          m_valid;
    bit          m_ovf;
    bit          m_frm;
    int          m_err;
    int          ovf_seen;
    int          frm_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          valid_old;
        bit          ovf_n;
        bit          frm_n;
        logic [63:0] w;
        if (!rst_n) begin
            m_pairs.delete();
            m_rec = 0; m_data = '0; m_valid = 0;
            m_ovf = 0; m_frm = 0; m_err = 0;
            return;
        end
        if ((m_ovf || m_frm) && m_err < 255) m_err++;
        valid_old = m_valid;
        ovf_n = 0;
        frm_n = 0;
        if (m_valid && data_ready) m_valid = 0;
        if (!m_rec) begin
            if (load) begin
                m_rec = 1;
                m_pairs.delete();
            end
        end else if (load) begin
            frm_n = (m_pairs.size() > 0);
            m_pairs.delete();
        end else if (shift) begin
            m_pairs.push_back(sreg_in);
            if (m_pairs.size() == 21) begin
                w = 0;
                foreach (m_pairs[k]) w = w * 4 + 64'(m_pairs[k]);
                m_pairs.delete();
                m_rec = 0;
                if (!valid_old || data_ready) begin
                    m_data  = w[41:0];
                    m_valid = 1;
                end else begin
                    ovf_n = 1;
                end
            end
        end
        m_ovf = ovf_n;
        m_frm = frm_n;
    endtask

    task automatic tick();
        @(posedge sclk);
        model_step();
        #1;
        chk("busy", 64'(busy), 64'(m_rec));
        chk("data_valid", 64'(data_valid), 64'(m_valid));
        chk("data_out", 64'(data_out), 64'(m_data));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("frm_err", 64'(frm_err), 64'(m_frm));
`ifdef SREG_DESER_ERR_CNT_EN
        chk("err_cnt", 64'(err_cnt), 64'(m_err));
`endif
        if (ovf) ovf_seen++;
        if (frm_err) frm_seen++;
    endtask

    task automatic idle_cycles(input int n);
        load = 0; shift = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Sends a full frame; optional 3-cycle stalls after pairs sa/sb; rdy_last forces ready on the last pair.
    task automatic send_frame(input logic [41:0] word, input int sa, input int sb, input bit rdy_last);
        logic [41:0] w;
        w = word;
        load = 1; shift = 0;
        tick();
        load = 0;
        for (int i = 0; i < 21; i++) begin
            shift = 1;
            sreg_in = w[41-2*i -: 2];
            if (rdy_last && i == 20) data_ready = 1;
            tick();
            if (i + 1 == sa || i + 1 == sb) begin
                shift = 0;
                for (int j = 0; j < 3; j++) tick();
            end
        end
        shift = 0;
    endtask

    initial begin
        rst_n = 0; load = 0; shift = 0; sreg_in = 2'b00; data_ready = 0;
        m_rec = 0; m_data = '0; m_valid = 0; m_ovf = 0; m_frm = 0; m_err = 0;
        ovf_seen = 0; frm_seen = 0;
        tick();
        tick();
        rst_n = 1;

        // Basic frame
        data_ready = 1;
        send_frame(42'h2AB_CDEF_0123, 0, 0, 0);
        chk("basic_word", 64'(data_out), 64'h2AB_CDEF_0123);
        chk("basic_busy_fell", 64'(busy), 64'd0);
        idle_cycles(2);

        // Stalls
        send_frame(42'h2AB_CDEF_0123, 5, 14, 0);
        chk("stall_word", 64'(data_out), 64'h2AB_CDEF_0123);
        idle_cycles(2);
        chk("stall_no_errs", 64'(ovf_seen + frm_seen), 64'd0);

        // Overflow
        data_ready = 0;
        send_frame(42'h3FF_FFFF_FFFF, 0, 0, 0);
        send_frame(42'h0, 0, 0, 0);
        idle_cycles(2);
        chk("ovf_word_kept", 64'(data_out), 64'h3FF_FFFF_FFFF);
        chk("ovf_pulses", 64'(ovf_seen), 64'd1);
        data_ready = 1;
        idle_cycles(2);

        // Abort
        load = 1; tick(); load = 0;
        for (int i = 0; i < 7; i++) begin
            shift = 1; sreg_in = 2'(i); tick();
        end
        send_frame(42'h155_5555_5555, 0, 0, 0);
        idle_cycles(2);
        chk("abort_frm_pulses", 64'(frm_seen), 64'd1);
        chk("abort_word", 64'(data_out), 64'h155_5555_5555);

        // Back-to-back accept on the completion cycle
        data_ready = 0;
        send_frame(42'h123_4567_89AB, 0, 0, 0);
        send_frame(42'h0AA_BBCC_DDEE, 0, 0, 1);
        chk("b2b_valid_held", 64'(data_valid), 64'd1);
        chk("b2b_new_word", 64'(data_out), 64'h0AA_BBCC_DDEE);
        chk("b2b_no_ovf", 64'(ovf_seen), 64'd1);
        idle_cycles(2);

        // Reset mid-frame
        load = 1; tick(); load = 0;
        for (int i = 0; i < 10; i++) begin
            shift = 1; sreg_in = 2'b11; tick();
        end
        shift = 0; rst_n = 0;
        tick();
        rst_n = 1;
        send_frame(42'h0F0_F0F0_F0F0, 0, 0, 0);
        chk("rst_word", 64'(data_out), 64'h0F0_F0F0_F0F0);
`ifdef SREG_DESER_ERR_CNT_EN
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
        idle_cycles(2);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst_n      = ($urandom_range(0, 299) != 0);
            load       = ($urandom_range(0, 39) == 0);
            shift      = ($urandom_range(0, 3) != 0);
            sreg_in    = 2'($urandom);
            data_ready = ($urandom_range(0, 2) == 0);
            tick();
        end
        rst_n = 1; load = 0; shift = 0;
        idle_cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
